// File: rtl/arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_e;

    // Ceiling log2, never below 1 so index ports keep a legal width.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result++;
        end
        return (result == 0) ? 1 : result;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first set request at or after ptr.
module rr_pick
    import arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 8,
    parameter int unsigned IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   winner
);

    logic [NUM_REQ-1:0] rotated;
    logic [IDX_W-1:0]   offset;
    logic [IDX_W:0]     sum;

    always_comb begin
        // Rotate right by ptr so the highest-priority requester lands at bit 0.
        rotated = NUM_REQ'({req, req} >> ptr);
        found   = |rotated;
        offset  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = IDX_W'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
            sum = sum - (IDX_W + 1)'(NUM_REQ);
        end
        winner = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// N-way round-robin arbiter with per-requester burst credits and zero-bubble handover.
module weighted_rr_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 8,
    parameter int unsigned WEIGHT_W = 4,
    localparam int unsigned IDX_W   = clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rstN,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*WEIGHT_W-1:0] weight,
    input  logic                        done,
    output logic [NUM_REQ-1:0]          grant,
    output logic [IDX_W-1:0]            grant_idx,
    output logic                        grant_valid
);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [WEIGHT_W-1:0] credit_q, credit_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    logic                found;
    logic [IDX_W-1:0]    winner;
    logic [WEIGHT_W-1:0] win_weight;
    logic                rel;
    logic                load;
    logic                clear;

    // ptr already points past the last winner, so one picker serves both IDLE and release.
    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .found  (found),
        .winner (winner)
    );

    assign win_weight = weight[32'(winner) * WEIGHT_W +: WEIGHT_W];

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        grant_d  = grant_q;
        idx_d    = idx_q;
        rel      = 1'b0;
        load     = 1'b0;
        clear    = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                load = found;
            end
            ARB_GRANT: begin
                rel = !req[idx_q] || (done && (credit_q == WEIGHT_W'(1)));
                if (rel) begin
                    load  = found;
                    clear = !found;
                end else if (done) begin
                    credit_d = credit_q - WEIGHT_W'(1);
                end
            end
            default: begin
                clear = 1'b1;
            end
        endcase

        if (load) begin
            state_d  = ARB_GRANT;
            grant_d  = NUM_REQ'(1) << winner;
            idx_d    = winner;
            credit_d = (win_weight == '0) ? WEIGHT_W'(1) : win_weight;
            ptr_d    = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
        end else if (clear) begin
            state_d  = ARB_IDLE;
            grant_d  = '0;
            idx_d    = '0;
            credit_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= ARB_IDLE;
            ptr_q    <= '0;
            credit_q <= '0;
            grant_q  <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            grant_q  <= grant_d;
            idx_q    <= idx_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign grant_valid = (state_q == ARB_GRANT);

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Directed bench for weighted_rr_arbiter: an 8-way and a 5-way instance.
module tb_weighted_rr_arbiter;

    logic        clk;
    logic        rstN;

    logic [7:0]  req_a;
    logic [31:0] weight_a;
    logic        done_a;
    logic [7:0]  grant_a;
    logic [2:0]  idx_a;
    logic        valid_a;

    logic [4:0]  req_b;
    logic [19:0] weight_b;
    logic        done_b;
    logic [4:0]  grant_b;
    logic [2:0]  idx_b;
    logic        valid_b;

    int checks;
    int errors;

    weighted_rr_arbiter #(
        .NUM_REQ  (8),
        .WEIGHT_W (4)
    ) dut_a (
        .clk         (clk),
        .rstN        (rstN),
        .req         (req_a),
        .weight      (weight_a),
        .done        (done_a),
        .grant       (grant_a),
        .grant_idx   (idx_a),
        .grant_valid (valid_a)
    );

    weighted_rr_arbiter #(
        .NUM_REQ  (5),
        .WEIGHT_W (4)
    ) dut_b (
        .clk         (clk),
        .rstN        (rstN),
        .req         (req_b),
        .weight      (weight_b),
        .done        (done_b),
        .grant       (grant_b),
        .grant_idx   (idx_b),
        .grant_valid (valid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic [7:0] g, input logic [2:0] i,
                           input logic v);
        check({tag, " grant"}, 64'(grant_a), 64'(g));
        check({tag, " idx"}, 64'(idx_a), 64'(i));
        check({tag, " valid"}, 64'(valid_a), 64'(v));
    endtask

    initial begin
        logic [7:0] exp_g;

        checks   = 0;
        errors   = 0;
        rstN     = 1'b0;
        req_a    = '0;
        done_a   = 1'b0;
        weight_a = {8{4'd1}};
        req_b    = '0;
        done_b   = 1'b0;
        weight_b = {5{4'd1}};

        #3;
        check_a("reset", 8'h00, 3'd0, 1'b0);
        check("reset b grant", 64'(grant_b), 64'h0);
        #9;
        rstN = 1'b1;

        // Idle with done pulses: must stay idle.
        done_a = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check_a("idle", 8'h00, 3'd0, 1'b0);
        end

        // All weights 1, everyone requesting: one grant per cycle, wrapping 7 -> 0.
        req_a = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            step();
            exp_g = 8'h01 << (k % 8);
            check_a("rotate", exp_g, 3'(k % 8), 1'b1);
        end
        req_a  = 8'h00;
        done_a = 1'b0;
        step();
        check_a("rotate drop", 8'h00, 3'd0, 1'b0);

        // ptr is 1. weight[2]=3, weight[5]=1.
        weight_a[2*4 +: 4] = 4'd3;
        weight_a[5*4 +: 4] = 4'd1;
        req_a  = 8'h24;
        done_a = 1'b1;
        step();
        check_a("burst w3 a", 8'h04, 3'd2, 1'b1);
        step();
        check_a("burst w3 b", 8'h04, 3'd2, 1'b1);
        step();
        check_a("burst w3 c", 8'h04, 3'd2, 1'b1);
        step();
        check_a("burst w1", 8'h20, 3'd5, 1'b1);
        step();
        check_a("burst back", 8'h04, 3'd2, 1'b1);
        req_a  = 8'h00;
        done_a = 1'b0;
        step();
        check_a("burst idle", 8'h00, 3'd0, 1'b0);

        // Move ptr to 5 via requester 4, then req=09 picks 0.
        req_a = 8'h10;
        step();
        check_a("ptr move", 8'h10, 3'd4, 1'b1);
        req_a = 8'h09;
        weight_a[3*4 +: 4] = 4'd5;
        step();
        check_a("drop pre", 8'h01, 3'd0, 1'b1);
        // Holder drops without done; 3 takes over with credit 5.
        req_a = 8'h08;
        step();
        check_a("drop handover", 8'h08, 3'd3, 1'b1);
        // Requester 6 does not pre-empt; 4 dones hold, 5th releases.
        req_a  = 8'h48;
        done_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check_a("credit5 hold", 8'h08, 3'd3, 1'b1);
        end
        step();
        check_a("credit5 release", 8'h40, 3'd6, 1'b1);
        req_a  = 8'h00;
        done_a = 1'b0;
        step();
        check_a("drop idle", 8'h00, 3'd0, 1'b0);

        // Sole requester is re-granted back-to-back.
        weight_a[0*4 +: 4] = 4'd2;
        req_a  = 8'h01;
        done_a = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check_a("sole", 8'h01, 3'd0, 1'b1);
        end
        req_a  = 8'h00;
        done_a = 1'b0;
        step();
        check_a("sole idle", 8'h00, 3'd0, 1'b0);

        // 5-way: weight 0 acts as 1, and winner 4 wraps ptr to 0.
        weight_b[4*4 +: 4] = 4'd0;
        weight_b[0*4 +: 4] = 4'd3;
        req_b = 5'h10;
        step();
        check("b grant4", 64'(grant_b), 64'h10);
        check("b idx4", 64'(idx_b), 64'd4);
        check("b valid4", 64'(valid_b), 64'd1);
        req_b  = 5'h11;
        done_b = 1'b1;
        step();
        check("b wrap grant", 64'(grant_b), 64'h01);
        check("b wrap idx", 64'(idx_b), 64'd0);
        done_b = 1'b0;
        step();
        check("b hold", 64'(grant_b), 64'h01);

        // Asynchronous reset mid-burst.
        #2;
        rstN = 1'b0;
        #1;
        check("b async grant", 64'(grant_b), 64'h00);
        check("b async valid", 64'(valid_b), 64'd0);
        check("b async idx", 64'(idx_b), 64'd0);
        #10;
        rstN  = 1'b1;
        req_b = 5'h11;
        step();
        check("b restart", 64'(grant_b), 64'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
